// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: moves 32-bit words between a byte-wide UART and two word
// memories (instruction / data) so they can be loaded or dumped while the CPU
// is held off the memory ports.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   uart_on             : 1 hands both memories to the UART path
//   uart_mode           : 0 = load memory from RX, 1 = dump memory to TX
//   uart_ram_id         : 0 = instruction memory, 1 = data memory
//   rx_valid, rx_data   : one-cycle strobe with a received byte
//   tx_ready            : transmitter idle
//   tx_start, tx_data   : one-cycle transmit request with its byte
//   im_rdata, dm_rdata  : memory read data, valid one cycle after mem_addr
//   mem_addr, mem_wdata : UART-side word address and assembled write word
//   im_we, dm_we        : one-cycle write enables
//   uart_sel            : memory port mux select, 1 = UART side owns it
//   im_done, dm_done    : operation on that memory completed
module uart_mem_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int IM_WORDS = 256,
  parameter int DM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_on,
  input  logic              uart_mode,
  input  logic              uart_ram_id,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic [31:0]       im_rdata,
  input  logic [31:0]       dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              im_we,
  output logic              dm_we,
  output logic              uart_sel,
  output logic              im_done,
  output logic              dm_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_SEND    = 3'd5;
  localparam logic [2:0] S_TX_BUSY = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [ADDR_W-1:0] IM_LAST = ADDR_W'(IM_WORDS - 1);
  localparam logic [ADDR_W-1:0] DM_LAST = ADDR_W'(DM_WORDS - 1);

  logic [2:0]  state;
  logic        id_q;          // memory selected when IDLE was left
  logic [1:0]  byte_cnt;
  logic [31:0] shreg;         // dump word, shifted right one byte per send
  logic        ready_dropped; // tx_ready has gone low since the last tx_start
  logic        last_addr;

  assign last_addr = (mem_addr == (id_q ? DM_LAST : IM_LAST));

  // The transfer direction is captured by which path IDLE branches into, so
  // only the memory select needs its own latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      id_q          <= 1'b0;
      byte_cnt      <= '0;
      shreg         <= '0;
      ready_dropped <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      tx_data       <= '0;
      tx_start      <= 1'b0;
      im_we         <= 1'b0;
      dm_we         <= 1'b0;
      uart_sel      <= 1'b0;
      im_done       <= 1'b0;
      dm_done       <= 1'b0;
    end else begin
      im_we    <= 1'b0;
      dm_we    <= 1'b0;
      tx_start <= 1'b0;
      if (!uart_on) begin
        // Abort wins over everything, including a byte arriving this cycle.
        state    <= S_IDLE;
        uart_sel <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            id_q     <= uart_ram_id;
            mem_addr <= '0;
            byte_cnt <= '0;
            uart_sel <= 1'b1;
            if (uart_ram_id) dm_done <= 1'b0;
            else             im_done <= 1'b0;
            state <= uart_mode ? S_RD_ADDR : S_LOAD;
          end
          S_LOAD: begin
            if (rx_valid) begin
              mem_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                // Enable is registered so it is high exactly while in WRITE.
                im_we <= ~id_q;
                dm_we <= id_q;
                state <= S_WRITE;
              end
            end
          end
          S_WRITE: begin
            if (last_addr) begin
              state <= S_DONE;
            end else begin
              mem_addr <= mem_addr + 1'b1;
              state    <= S_LOAD;
            end
          end
          S_RD_ADDR: state <= S_RD_WAIT;
          S_RD_WAIT: begin
            shreg    <= id_q ? dm_rdata : im_rdata;
            byte_cnt <= '0;
            state    <= S_SEND;
          end
          S_SEND: begin
            if (tx_ready) begin
              tx_start      <= 1'b1;
              tx_data       <= shreg[7:0];
              shreg         <= {8'h00, shreg[31:8]};
              ready_dropped <= 1'b0;
              state         <= S_TX_BUSY;
            end
          end
          S_TX_BUSY: begin
            if (!tx_ready) begin
              ready_dropped <= 1'b1;
            end else if (ready_dropped) begin
              if (byte_cnt != 2'd3) begin
                byte_cnt <= byte_cnt + 2'd1;
                state    <= S_SEND;
              end else if (last_addr) begin
                state <= S_DONE;
              end else begin
                mem_addr <= mem_addr + 1'b1;
                state    <= S_RD_ADDR;
              end
            end
          end
          S_DONE: begin
            if (id_q) dm_done <= 1'b1;
            else      im_done <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_ctrl.sv
module tb_uart_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_on = 1'b0;
  logic        uart_mode = 1'b0;
  logic        uart_ram_id = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b1;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] im_rdata = 32'h0;
  logic [31:0] dm_rdata = 32'h0;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        im_we, dm_we, uart_sel, im_done, dm_done;

  int checks = 0;
  int failures = 0;

  logic        wr_dm[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  tx_bytes[$];
  int          tx_cnt = 0;

  uart_mem_ctrl #(.ADDR_W(8), .IM_WORDS(2), .DM_WORDS(1)) dut (
    .clk(clk), .reset(reset), .uart_on(uart_on), .uart_mode(uart_mode),
    .uart_ram_id(uart_ram_id), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .im_rdata(im_rdata), .dm_rdata(dm_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .im_we(im_we), .dm_we(dm_we), .uart_sel(uart_sel),
    .im_done(im_done), .dm_done(dm_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data memory word 0 holds A1B2C3D4, readable
  // only once the UART side owns the port.
  always @(posedge clk) begin
    dm_rdata <= (uart_sel && mem_addr == 8'd0) ? 32'hA1B2C3D4 : 32'h0;
    im_rdata <= 32'h55AA55AA;
  end

  // Transmitter: busy for five cycles after each start.
  always begin
    @(negedge clk);
    if (tx_start) begin
      tx_ready = 1'b0;
      repeat (5) @(negedge clk);
      tx_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (im_we) begin wr_dm.push_back(1'b0); wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata); end
    if (dm_we) begin wr_dm.push_back(1'b1); wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata); end
    if (tx_start) begin tx_cnt++; tx_bytes.push_back(tx_data); end
  end

  task automatic clear_logs();
    wr_dm.delete(); wr_addr.delete(); wr_data.delete(); tx_bytes.delete(); tx_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_op(input logic mode, input logic id);
    @(negedge clk); uart_mode = mode; uart_ram_id = id; uart_on = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic stop_op();
    @(negedge clk); uart_on = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({uart_sel, tx_start, im_we, dm_we, im_done, dm_done} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {uart_sel, tx_start, im_we, dm_we, im_done, dm_done}); end
    checks++; if ({mem_addr, tx_data, mem_wdata} !== 48'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {mem_addr, tx_data, mem_wdata}); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (uart_sel !== 1'b0) begin failures++; $display("FAIL idle_sel got=%b exp=0", uart_sel); end
  endtask

  task automatic test_im_load();
    logic [7:0]  b [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [31:0] exp_d [2] = '{32'h12345678, 32'hDEADBEEF};
    clear_logs();
    start_op(1'b0, 1'b0);
    checks++; if (uart_sel !== 1'b1) begin failures++; $display("FAIL load_sel got=%b exp=1", uart_sel); end
    for (int i = 0; i < 8; i++) send_byte(b[i]);
    repeat (4) @(negedge clk);
    checks++; if (wr_data.size() !== 2) begin failures++; $display("FAIL im_wr_count got=%0d exp=2", wr_data.size()); end
    for (int i = 0; i < wr_data.size() && i < 2; i++) begin
      checks++; if ({wr_dm[i], wr_addr[i], wr_data[i]} !== {1'b0, 8'(i), exp_d[i]}) begin
        failures++; $display("FAIL im_wr%0d got=dm%b a%h d%h exp=dm0 a%h d%h", i, wr_dm[i], wr_addr[i], wr_data[i], 8'(i), exp_d[i]); end
    end
    checks++; if ({im_done, dm_done} !== 2'b10) begin failures++; $display("FAIL im_done got=%b exp=10", {im_done, dm_done}); end
    checks++; if (mem_addr !== 8'd1) begin failures++; $display("FAIL im_last_addr got=%h exp=01", mem_addr); end
    stop_op();
  endtask

  task automatic test_mode_ignored();
    clear_logs();
    start_op(1'b0, 1'b1);
    uart_mode = 1'b1; uart_ram_id = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (4) @(negedge clk);
    checks++; if (wr_data.size() !== 1) begin failures++; $display("FAIL latch_wr_count got=%0d exp=1", wr_data.size()); end
    if (wr_data.size() > 0) begin
      checks++; if ({wr_dm[0], wr_addr[0], wr_data[0]} !== {1'b1, 8'h00, 32'h44332211}) begin
        failures++; $display("FAIL latch_wr got=dm%b a%h d%h exp=dm1 a00 d44332211", wr_dm[0], wr_addr[0], wr_data[0]); end
    end
    checks++; if (tx_cnt !== 0) begin failures++; $display("FAIL latch_no_tx got=%0d exp=0", tx_cnt); end
    checks++; if ({im_done, dm_done} !== 2'b11) begin failures++; $display("FAIL latch_done got=%b exp=11", {im_done, dm_done}); end
  endtask

  task automatic test_done_hold();
    @(negedge clk); uart_on = 1'b0;
    @(negedge clk);
    checks++; if (uart_sel !== 1'b0) begin failures++; $display("FAIL off_sel got=%b exp=0", uart_sel); end
    repeat (5) @(negedge clk);
    checks++; if (dm_done !== 1'b1) begin failures++; $display("FAIL dm_done_hold got=%b exp=1", dm_done); end
    uart_mode = 1'b0; uart_ram_id = 1'b1; uart_on = 1'b1;
    @(negedge clk);
    checks++; if ({uart_sel, im_done, dm_done} !== 3'b110) begin
      failures++; $display("FAIL reenter_clear got=%b exp=110", {uart_sel, im_done, dm_done}); end
    stop_op();
  endtask

  task automatic test_partial_discard();
    clear_logs();
    start_op(1'b0, 1'b0);
    send_byte(8'h01); send_byte(8'h02);
    stop_op();
    checks++; if ({wr_data.size() == 0, im_done, dm_done} !== 3'b100) begin
      failures++; $display("FAIL partial_drop got=n%0d done%b%b exp=n0 done00", wr_data.size(), im_done, dm_done); end
    start_op(1'b0, 1'b0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h04; uart_on = 1'b0;
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_data.size() !== 0) begin failures++; $display("FAIL abort_priority got=%0d exp=0", wr_data.size()); end
    start_op(1'b0, 1'b0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    repeat (3) @(negedge clk);
    checks++; if (wr_data.size() !== 1) begin failures++; $display("FAIL resume_count got=%0d exp=1", wr_data.size()); end
    if (wr_data.size() > 0) begin
      checks++; if ({wr_dm[0], wr_addr[0], wr_data[0]} !== {1'b0, 8'h00, 32'h04030201}) begin
        failures++; $display("FAIL resume_wr got=dm%b a%h d%h exp=dm0 a00 d04030201", wr_dm[0], wr_addr[0], wr_data[0]); end
    end
    checks++; if ({im_done, mem_addr} !== {1'b0, 8'h01}) begin
      failures++; $display("FAIL resume_state got=%b/%h exp=0/01", im_done, mem_addr); end
    stop_op();
  endtask

  task automatic test_dump();
    logic [7:0] exp_b [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    int n = 0;
    clear_logs();
    start_op(1'b1, 1'b1);
    while (!dm_done && n < 300) begin @(negedge clk); n++; end
    checks++; if (dm_done !== 1'b1) begin failures++; $display("FAIL dump_done got=%b exp=1 (timeout)", dm_done); end
    repeat (10) @(negedge clk);
    checks++; if (tx_cnt !== 4) begin failures++; $display("FAIL dump_starts got=%0d exp=4", tx_cnt); end
    for (int i = 0; i < tx_bytes.size() && i < 4; i++) begin
      checks++; if (tx_bytes[i] !== exp_b[i]) begin
        failures++; $display("FAIL dump_byte%0d got=%h exp=%h", i, tx_bytes[i], exp_b[i]); end
    end
    checks++; if (wr_data.size() !== 0) begin failures++; $display("FAIL dump_no_write got=%0d exp=0", wr_data.size()); end
    stop_op();
  endtask

  task automatic test_reset_mid_dump();
    int n = 0;
    int snap;
    clear_logs();
    start_op(1'b1, 1'b1);
    while (!tx_start && n < 100) begin @(negedge clk); n++; end
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL busy_reach got=%b exp=1 (timeout)", tx_start); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({uart_sel, tx_start, im_we, dm_we, im_done, dm_done} !== 6'b0) begin
      failures++; $display("FAIL async_flags got=%b exp=000000", {uart_sel, tx_start, im_we, dm_we, im_done, dm_done}); end
    checks++; if ({mem_addr, tx_data, mem_wdata} !== 48'h0) begin
      failures++; $display("FAIL async_data got=%h exp=0", {mem_addr, tx_data, mem_wdata}); end
    uart_on = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    snap = tx_cnt;
    repeat (20) @(negedge clk);
    checks++; if (tx_cnt !== snap || uart_sel !== 1'b0) begin
      failures++; $display("FAIL post_reset got=starts%0d sel%b exp=starts%0d sel0", tx_cnt, uart_sel, snap); end
  endtask

  initial begin
    test_reset();
    test_im_load();
    test_mode_ignored();
    test_done_hold();
    test_partial_discard();
    test_dump();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_mem_ctrl.md
UART_MEM_CTRL -- requirements
Module: uart_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address width of each memory.
REQ-002 SHALL have parameter IM_WORDS, default 256, meaning number of words loaded or dumped for the instruction memory.
REQ-003 SHALL have parameter DM_WORDS, default 256, meaning number of words loaded or dumped for the data memory.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-006 SHALL have port uart_on, input, 1, meaning 1 gives both memories to the UART path and 0 gives them to the CPU.
REQ-007 SHALL have port uart_mode, input, 1, meaning 0 loads memory from RX and 1 dumps memory to TX.
REQ-008 SHALL have port uart_ram_id, input, 1, meaning 0 selects instruction memory and 1 selects data memory.
REQ-009 SHALL have port rx_valid / rx_data, input, 1 / 8, meaning a one-cycle strobe with the received byte.
REQ-010 SHALL have port tx_ready, input, 1, meaning the transmitter is idle.
REQ-011 SHALL have port tx_start / tx_data, output, 1 / 8, meaning a one-cycle transmit request with its byte.
REQ-012 SHALL have port im_rdata / dm_rdata, input, 32 each, meaning memory read data, valid one cycle after the address.
REQ-013 SHALL have port mem_addr, output, ADDR_W, meaning the UART-side word address.
REQ-014 SHALL have port mem_wdata, output, 32, meaning the assembled word.
REQ-015 SHALL have port im_we / dm_we, output, 1 each, meaning one-cycle write enables.
REQ-016 SHALL have port uart_sel, output, 1, meaning the memory port mux select, where 1 means the UART side owns it.
REQ-017 SHALL have port im_done / dm_done, output, 1 each, meaning the operation on that memory has completed (driven to led[7] / led[6]).

Function
REQ-018 SHALL implement states IDLE, LOAD, WRITE, RD_ADDR, RD_WAIT, SEND, TX_BUSY, DONE.
REQ-019 SHALL leave IDLE only when uart_on=1, and on leaving SHALL latch uart_mode and uart_ram_id; later changes to either are ignored until IDLE is re-entered.
REQ-020 SHALL, on leaving IDLE, clear the address counter and the byte counter, and clear only the selected done flag.
REQ-021 SHALL drive uart_sel as 1 in every state except IDLE; it is registered and tracks the state.
REQ-022 SHALL, in LOAD, place each rx_valid byte into word lane byte_cnt, little-endian: the first byte goes to bits [7:0] and the fourth to bits [31:24].
REQ-023 SHALL, on the fourth byte, go to WRITE; WRITE pulses exactly one of im_we / dm_we for one cycle with the current mem_addr and mem_wdata.
REQ-024 SHALL, after WRITE, increment the address; if the written address was N-1 (N = IM_WORDS or DM_WORDS) it goes to DONE, otherwise it returns to LOAD.
REQ-025 SHALL ignore rx_valid in WRITE, because the UART byte time is at least 10k cycles.
REQ-026 SHALL, for a dump, drive mem_addr in RD_ADDR, wait one cycle in RD_WAIT, then latch the selected rdata into a shift register.
REQ-027 SHALL, in SEND, pulse tx_start for one cycle with tx_data = current low byte once tx_ready=1, then go to TX_BUSY.
REQ-028 SHALL leave TX_BUSY when tx_ready returns to 1 after having dropped to 0; it then sends the next byte, the next address, or goes to DONE after the fourth byte of word N-1.
REQ-029 SHALL, in DONE, set the selected done flag and hold it; it stays in DONE while uart_on=1.
REQ-030 SHALL, whenever uart_on=0 in any state, go to IDLE on the next clock.
REQ-031 SHALL discard a partial word when forced to IDLE that way; no write is issued and the done flags are unchanged.
REQ-032 SHALL, when rx_valid and uart_on falling coincide, give priority to uart_on falling, so the byte is dropped.
REQ-033 SHALL have an address counter ADDR_W wide that never wraps; DONE is reached exactly at N-1.

Reset
REQ-034 SHALL, on reset=0, asynchronously force: state IDLE; counters 0; uart_sel, im_we, dm_we, tx_start 0; tx_data, mem_wdata, mem_addr 0; im_done, dm_done 0.
REQ-035 SHALL have reset release take effect at the first clock edge after reset=1.

Verification
REQ-036 SHALL be covered by: IM_WORDS=2, uart_on=1, mode=0, id=0, bytes 78 56 34 12 EF BE AD DE -> im_we at addr 0 with 0x12345678, at addr 1 with 0xDEADBEEF, then im_done=1 and dm_done=0.
REQ-037 SHALL be covered by: DM load, then uart_on=0 -> uart_sel=0 in 1 cycle, dm_done held at 1; then uart_on=1 again -> dm_done cleared.
REQ-038 SHALL be covered by: dump with DM_WORDS=1, dm_rdata=0xA1B2C3D4, tx_ready toggled by a TX model -> tx_data sequence D4 C3 B2 A1 with exactly 4 tx_start pulses, then dm_done=1.
REQ-039 SHALL be covered by: 2 bytes received, then uart_on=0, then uart_on=1 and 4 bytes 01 02 03 04 -> a single write of 0x04030201 at addr 0.
REQ-040 SHALL be covered by: reset asserted mid-dump in TX_BUSY -> all outputs 0 asynchronously, with no further tx_start.
REQ-041 SHALL be covered by: uart_mode toggled while in LOAD -> no effect; bytes still load into the latched memory.
